psum_round_sched: RTL and testbench
===================================

# psum_round_sched

Clocked sequencer in front of the partial-sum adder of the SNN accelerator. It accepts 64-bit partial-sum and membrane-potential packets from the NoC and buffers one partial sum per PE plus the stored membrane potential. Once a round is complete, it issues the round to the adder through a single valid/ready handshake. It also owns the timestep counter, including the rule for when a stored membrane potential is required, and flags malformed or duplicate traffic.

## Interface
- WIDTH, 64, packet width
- NUM_PE, 5, PEs contributing partial sums per round
- PSUM_W, 8, partial-sum and membrane-potential width
- NUM_TIMESTEPS, 5, rounds per image; must be ≥2
- TS_W, 3, timestep counter width; must satisfy NUM_TIMESTEPS ≤ 2^TS_W
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  NoC packet valid
- in_ready  out  1  block can accept a packet
- in_data  in  WIDTH  packet: [63:60] source address, [55:54] type, [37:30] membrane potential, [7:0] partial sum
- add_valid  out  1  complete round presented to the adder
- add_ready  in  1  adder accepts the round
- add_psum  out  NUM_PE*PSUM_W  partial sums, slot k at [k*PSUM_W +: PSUM_W]
- add_mem_pot  out  PSUM_W  stored membrane potential; 0 when add_use_mem=0
- add_use_mem  out  1  adder accumulates onto add_mem_pot (1) or starts fresh (0)
- add_ts  out  TS_W  timestep index of the issued round
- round_done  out  1  one-cycle pulse on acceptance of the last timestep of an image
- err  out  1  one-cycle pulse when an accepted packet is dropped

## Operation
- States: COLLECT and ISSUE. Reset enters COLLECT with ts=0, all slot-valid bits clear and all slot data cleared to 0.
- in_ready = (state==COLLECT) && !reset. A packet is accepted on any edge where in_valid && in_ready.
- Decode order, first match wins:
  - type==2'b10 is a membrane packet. It writes mem_slot from [37:30].
  - source 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1001 map to PE slots 0–4. The slot is written from [7:0].
  - Any other source is dropped and pulses err.
- Drop rules:
  - A packet targeting a slot whose valid bit is already set is dropped. The first value is kept and err pulses.
  - A membrane packet while ts==0 is dropped and err pulses.
- Round completion: all NUM_PE PE slots are valid, and mem_slot is valid when ts≠0.
- COLLECT→ISSUE: on the edge that captures the last required packet.
- In ISSUE:
  - add_valid=1.
  - add_psum, add_mem_pot, add_use_mem=(ts≠0) and add_ts=ts are held stable until the handshake completes.
  - in_valid is ignored.
- ISSUE→COLLECT: on the edge where add_ready=1.
  - All slot-valid bits clear and slot data is zeroed.
  - ts increments. If ts==NUM_TIMESTEPS-1, ts wraps to 0 and round_done pulses in the following cycle.
- Packets may arrive in any order. Only the set of slots matters.
- reset takes priority over every event, including a pending adder handshake. A round not yet accepted is discarded.

## Timing
- Reset values: in_ready=0 during reset and 1 the cycle after it deasserts. add_valid=0, add_psum=0, add_mem_pot=0, add_use_mem=0, add_ts=0, round_done=0, err=0.
- All outputs except in_ready are registered. in_ready is a combinational decode of the state register.
- Latency: add_valid rises in the cycle after the completing packet is accepted.
- Minimum round: NUM_PE accept cycles, plus one more when ts≠0, plus one ISSUE cycle. Back-to-back accepts occur at 1 per cycle.
- in_ready returns to 1 in the cycle after the add handshake.
- err and round_done are single-cycle pulses. They are registered from the edge that caused them.

## Test plan
- Reset, then send 5 PE packets with psum 1,2,3,4,5 on sources 0,1,2,3,9 → add_valid the next cycle; add_psum slots = 1..5, add_use_mem=0, add_ts=0.
- At ts=1, send 5 PE packets in reverse order, then a type-2'b10 packet with [37:30]=0x20 → ISSUE only after the membrane packet; add_mem_pot=0x20, add_use_mem=1, add_ts=1.
- Hold add_ready=0 for 4 cycles in ISSUE → outputs stable, in_ready=0, in_valid traffic ignored; with add_ready=1, ts advances and in_ready=1 the next cycle.
- Send PE0 twice with 0x11 then 0x22; send source 4'b0101; send a membrane packet at ts=0 → err pulses three times, slot 0 issues 0x11.
- Run 5 complete rounds → add_ts sequences 0,1,2,3,4; round_done pulses once after round 4; the next round has add_ts=0 and add_use_mem=0.
- Assert reset for one cycle while in ISSUE with 3 slots of the next round pending → all outputs return to reset values; the next round needs all 5 PE packets and reports ts=0.

Source files
------------

// File: rtl/psum_round_sched_if.sv
// NoC-side packet handshake and adder-side round handshake of psum_round_sched.
interface psum_round_sched_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NUM_PE = 5,
    parameter int unsigned PSUM_W = 8,
    parameter int unsigned TS_W   = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic                     add_valid;
    logic                     add_ready;
    logic [NUM_PE*PSUM_W-1:0] add_psum;
    logic [PSUM_W-1:0]        add_mem_pot;
    logic                     add_use_mem;
    logic [TS_W-1:0]          add_ts;
    logic                     round_done;
    logic                     err;

    // Environment side: drives packets and adder acceptance.
    modport master (
        output in_valid, in_data, add_ready,
        input  in_ready, add_valid, add_psum, add_mem_pot, add_use_mem, add_ts,
               round_done, err
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, add_ready,
        output in_ready, add_valid, add_psum, add_mem_pot, add_use_mem, add_ts,
               round_done, err
    );
endinterface

// File: rtl/psum_round_sched.sv
// Collects one partial sum per PE (plus membrane potential after the first
// timestep) into a round, issues it to the adder and tracks the timestep.
module psum_round_sched #(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned NUM_PE        = 5,
    parameter int unsigned PSUM_W        = 8,
    parameter int unsigned NUM_TIMESTEPS = 5,
    parameter int unsigned TS_W          = 3
) (
    input  logic               clk,
    input  logic               reset,
    psum_round_sched_if.slave  bus
);
    localparam int unsigned SLOT_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned MEM_LSB = 30;
    localparam int unsigned LAST_TS = NUM_TIMESTEPS - 1;

    typedef enum logic {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } stateE;

    stateE state;
    stateE nextState;

    logic [NUM_PE-1:0][PSUM_W-1:0] peSlot;
    logic [NUM_PE-1:0]             peValid;
    logic [PSUM_W-1:0]             memSlot;
    logic                          memValid;
    logic [TS_W-1:0]               ts;
    logic                          useMemQ;
    logic                          addValidQ;
    logic                          errQ;
    logic                          roundDoneQ;
    logic                          inReady;

    logic [3:0]        srcAddr;
    logic [1:0]        pktType;
    logic [PSUM_W-1:0] pktMem;
    logic [PSUM_W-1:0] pktPsum;
    logic              isMem;
    logic              peHit;
    logic [SLOT_W-1:0] peIdx;
    logic              accept;
    logic              memWrite;
    logic              peWrite;
    logic              dropPkt;
    logic [NUM_PE-1:0] peValidNext;
    logic              memValidNext;
    logic              roundComplete;
    logic              handshake;
    logic              lastTs;
    logic              unusedBits;

    assign srcAddr    = bus.in_data[WIDTH-1 -: 4];
    assign pktType    = bus.in_data[55:54];
    assign pktMem     = bus.in_data[MEM_LSB +: PSUM_W];
    assign pktPsum    = bus.in_data[0 +: PSUM_W];
    assign unusedBits = ^{bus.in_data[59:56], bus.in_data[53:38], bus.in_data[29:8]};

    // Packet classification: membrane type first, then fixed source-to-slot map.
    always_comb begin
        isMem = (pktType == 2'b10);
        peHit = 1'b0;
        peIdx = '0;
        case (srcAddr)
            4'b0000: begin peHit = 1'b1; peIdx = SLOT_W'(0); end
            4'b0001: begin peHit = 1'b1; peIdx = SLOT_W'(1); end
            4'b0010: begin peHit = 1'b1; peIdx = SLOT_W'(2); end
            4'b0011: begin peHit = 1'b1; peIdx = SLOT_W'(3); end
            4'b1001: begin peHit = 1'b1; peIdx = SLOT_W'(4); end
            default: ;
        endcase
    end

    // Slot update decisions and round-complete detection for this edge.
    always_comb begin
        accept        = bus.in_valid && inReady;
        memWrite      = accept && isMem && (ts != '0) && !memValid;
        peWrite       = accept && !isMem && peHit && !peValid[peIdx];
        dropPkt       = accept && !memWrite && !peWrite;
        peValidNext   = peValid | (peWrite ? (NUM_PE'(1) << peIdx) : '0);
        memValidNext  = memValid | memWrite;
        roundComplete = (&peValidNext) && (memValidNext || (ts == '0));
        handshake     = (state == ISSUE) && bus.add_ready;
        lastTs        = (ts == TS_W'(LAST_TS));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            COLLECT: if (accept && roundComplete) nextState = ISSUE;
            ISSUE:   if (bus.add_ready)           nextState = COLLECT;
            default: nextState = COLLECT;
        endcase
    end

    // Output decode: NoC may push only while collecting and out of reset.
    always_comb begin
        inReady = (state == COLLECT) && !reset;
    end

    // Slot storage, timestep counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            peSlot     <= '0;
            peValid    <= '0;
            memSlot    <= '0;
            memValid   <= 1'b0;
            ts         <= '0;
            useMemQ    <= 1'b0;
            addValidQ  <= 1'b0;
            errQ       <= 1'b0;
            roundDoneQ <= 1'b0;
        end else begin
            addValidQ  <= (nextState == ISSUE);
            errQ       <= dropPkt;
            roundDoneQ <= handshake && lastTs;
            if (handshake) begin
                peSlot   <= '0;
                peValid  <= '0;
                memSlot  <= '0;
                memValid <= 1'b0;
                ts       <= lastTs ? '0 : ts + TS_W'(1);
                useMemQ  <= !lastTs;
            end else begin
                if (peWrite) begin
                    peSlot[peIdx] <= pktPsum;
                end
                if (memWrite) begin
                    memSlot <= pktMem;
                end
                peValid  <= peValidNext;
                memValid <= memValidNext;
            end
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.add_valid   = addValidQ;
    assign bus.add_psum    = peSlot;
    assign bus.add_mem_pot = memSlot;
    assign bus.add_use_mem = useMemQ;
    assign bus.add_ts      = ts;
    assign bus.err         = errQ;
    assign bus.round_done  = roundDoneQ;
endmodule

// File: tb/tb_psum_round_sched.sv
// Directed bench for psum_round_sched with a round-level reference model.
module tb_psum_round_sched;
    localparam int unsigned NPE = 5;
    localparam int unsigned NTS = 5;

    logic clk;
    logic reset;
    logic chkEn;
    int   nVec;
    int   nFail;
    int   errCount;
    int   doneCount;

    psum_round_sched_if #(.WIDTH(64), .NUM_PE(NPE), .PSUM_W(8), .TS_W(3)) bus ();

    psum_round_sched #(
        .WIDTH(64), .NUM_PE(NPE), .PSUM_W(8), .NUM_TIMESTEPS(NTS), .TS_W(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a round is a set of per-PE values plus an optional
    // membrane potential; it is handed over once the set is complete.
    logic [3:0] srcMap [NPE] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h9};
    logic [7:0] mPsum [NPE];
    bit         mHave [NPE];
    logic [7:0] mMem;
    bit         mMemHave;
    int         mTs;
    bit         mIssuing;
    bit         mErr;
    bit         mDone;
    bit         mInReset;

    function automatic logic [39:0] modelPsum();
        logic [39:0] e;
        for (int k = 0; k < NPE; k++) e[k*8 +: 8] = mPsum[k];
        return e;
    endfunction

    task automatic clearRound();
        for (int k = 0; k < NPE; k++) begin
            mPsum[k] = 8'h00;
            mHave[k] = 1'b0;
        end
        mMem     = 8'h00;
        mMemHave = 1'b0;
    endtask

    always @(posedge clk) begin
        int  slot;
        bit  full;
        mErr     = 1'b0;
        mDone    = 1'b0;
        mInReset = reset;
        if (reset) begin
            clearRound();
            mTs      = 0;
            mIssuing = 1'b0;
        end else if (mIssuing) begin
            if (bus.add_ready) begin
                clearRound();
                mIssuing = 1'b0;
                if (mTs == NTS - 1) begin
                    mTs   = 0;
                    mDone = 1'b1;
                end else begin
                    mTs = mTs + 1;
                end
            end
        end else if (bus.in_valid) begin
            slot = -1;
            for (int k = 0; k < NPE; k++) if (bus.in_data[63:60] == srcMap[k]) slot = k;
            if (bus.in_data[55:54] == 2'b10) begin
                if (mTs == 0 || mMemHave) mErr = 1'b1;
                else begin
                    mMem     = bus.in_data[37:30];
                    mMemHave = 1'b1;
                end
            end else if (slot < 0 || mHave[slot]) begin
                mErr = 1'b1;
            end else begin
                mPsum[slot] = bus.in_data[7:0];
                mHave[slot] = 1'b1;
            end
            full = 1'b1;
            for (int k = 0; k < NPE; k++) if (!mHave[k]) full = 1'b0;
            if (full && (mTs == 0 || mMemHave)) mIssuing = 1'b1;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.err === 1'b1) errCount++;
        if (bus.round_done === 1'b1) doneCount++;
        if (chkEn) begin
            chk("in_ready", 64'(bus.in_ready), 64'(!mIssuing && !reset));
            chk("add_valid", 64'(bus.add_valid), 64'(mIssuing));
            chk("err", 64'(bus.err), 64'(mErr));
            chk("round_done", 64'(bus.round_done), 64'(mDone));
            if (mIssuing) begin
                chk("add_psum", 64'(bus.add_psum), 64'(modelPsum()));
                chk("add_mem_pot", 64'(bus.add_mem_pot), 64'(mMemHave ? mMem : 8'h00));
                chk("add_use_mem", 64'(bus.add_use_mem), 64'(mTs != 0));
                chk("add_ts", 64'(bus.add_ts), 64'(mTs));
            end
            if (mInReset) begin
                chk("rst_psum", 64'(bus.add_psum), 64'h0);
                chk("rst_mem_pot", 64'(bus.add_mem_pot), 64'h0);
                chk("rst_use_mem", 64'(bus.add_use_mem), 64'h0);
                chk("rst_ts", 64'(bus.add_ts), 64'h0);
            end
        end
    end

    function automatic logic [63:0] mkPkt(input logic [3:0] src, input logic [1:0] typ,
                                          input logic [7:0] mp, input logic [7:0] ps);
        logic [63:0] d;
        d        = '0;
        d[59:56] = 4'h6;
        d[29:8]  = 22'h15A5A5;
        d[63:60] = src;
        d[55:54] = typ;
        d[37:30] = mp;
        d[7:0]   = ps;
        return d;
    endfunction

    task automatic sendPkt(input logic [3:0] src, input logic [1:0] typ,
                           input logic [7:0] mp, input logic [7:0] ps);
        bus.in_valid = 1'b1;
        bus.in_data  = mkPkt(src, typ, mp, ps);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIssue(input string name);
        int n;
        n = 0;
        while (bus.add_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.add_valid !== 1'b1) chk({name, "_timeout"}, 64'h0, 64'h1);
    endtask

    task automatic doHandshake();
        bus.add_ready = 1'b1;
        @(posedge clk); #1;
        bus.add_ready = 1'b0;
    endtask

    initial begin
        int errBase;
        nVec = 0; nFail = 0; errCount = 0; doneCount = 0;
        chkEn = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.add_ready = 1'b0;
        @(posedge clk); #1;
        chkEn = 1'b1;
        @(posedge clk); #1;
        chk("lit_rst_in_ready", 64'(bus.in_ready), 64'h0);
        chk("lit_rst_add_valid", 64'(bus.add_valid), 64'h0);
        chk("lit_rst_err", 64'(bus.err), 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("lit_in_ready_after_rst", 64'(bus.in_ready), 64'h1);

        // ts=0 round in order; add_valid must be up right after the last accept.
        sendPkt(4'h0, 2'b00, 8'h00, 8'h01);
        sendPkt(4'h1, 2'b00, 8'h00, 8'h02);
        sendPkt(4'h2, 2'b00, 8'h00, 8'h03);
        sendPkt(4'h3, 2'b00, 8'h00, 8'h04);
        sendPkt(4'h9, 2'b00, 8'h00, 8'h05);
        chk("lit_r0_valid", 64'(bus.add_valid), 64'h1);
        chk("lit_r0_psum", 64'(bus.add_psum), 64'h05_0403_0201);
        chk("lit_r0_use_mem", 64'(bus.add_use_mem), 64'h0);
        chk("lit_r0_ts", 64'(bus.add_ts), 64'h0);
        doHandshake();
        chk("lit_r0_in_ready", 64'(bus.in_ready), 64'h1);

        // ts=1 round in reverse order; issue waits for the membrane packet.
        sendPkt(4'h9, 2'b00, 8'h00, 8'h15);
        sendPkt(4'h3, 2'b00, 8'h00, 8'h14);
        sendPkt(4'h2, 2'b00, 8'h00, 8'h13);
        sendPkt(4'h1, 2'b00, 8'h00, 8'h12);
        sendPkt(4'h0, 2'b00, 8'h00, 8'h11);
        chk("lit_r1_wait_mem", 64'(bus.add_valid), 64'h0);
        sendPkt(4'hF, 2'b10, 8'h20, 8'h00);
        chk("lit_r1_valid", 64'(bus.add_valid), 64'h1);
        chk("lit_r1_psum", 64'(bus.add_psum), 64'h15_1413_1211);
        chk("lit_r1_mem", 64'(bus.add_mem_pot), 64'h20);
        chk("lit_r1_use_mem", 64'(bus.add_use_mem), 64'h1);
        chk("lit_r1_ts", 64'(bus.add_ts), 64'h1);

        // Adder stalls for 4 cycles while the NoC keeps pushing.
        bus.in_valid = 1'b1;
        bus.in_data  = mkPkt(4'h0, 2'b00, 8'h00, 8'hEE);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("lit_stall_in_ready", 64'(bus.in_ready), 64'h0);
            chk("lit_stall_psum", 64'(bus.add_psum), 64'h15_1413_1211);
            chk("lit_stall_mem", 64'(bus.add_mem_pot), 64'h20);
        end
        bus.in_valid = 1'b0;
        doHandshake();
        chk("lit_r1_release", 64'(bus.in_ready), 64'h1);
        chk("lit_r1_ts_next", 64'(bus.add_ts), 64'h2);

        // Rounds ts=2..4, ending in wrap and round_done.
        for (int r = 2; r < 5; r++) begin
            sendPkt(4'h3, 2'b00, 8'h00, 8'(16 * r + 3));
            sendPkt(4'hF, 2'b10, 8'(8'h30 + r), 8'h00);
            sendPkt(4'h0, 2'b00, 8'h00, 8'(16 * r));
            sendPkt(4'h9, 2'b00, 8'h00, 8'(16 * r + 4));
            sendPkt(4'h1, 2'b00, 8'h00, 8'(16 * r + 1));
            sendPkt(4'h2, 2'b00, 8'h00, 8'(16 * r + 2));
            waitIssue("rounds");
            chk("lit_rounds_ts", 64'(bus.add_ts), 64'(r));
            doHandshake();
        end
        chk("lit_round_done_pulse", 64'(bus.round_done), 64'h1);
        @(posedge clk); #1;
        chk("lit_round_done_end", 64'(bus.round_done), 64'h0);
        chk("lit_round_done_count", 64'(doneCount), 64'h1);

        // ts=0 again: duplicate, unknown source and early membrane all dropped.
        errBase = errCount;
        sendPkt(4'h0, 2'b00, 8'h00, 8'h11);
        sendPkt(4'h0, 2'b00, 8'h00, 8'h22);
        chk("lit_dup_err", 64'(bus.err), 64'h1);
        sendPkt(4'h5, 2'b00, 8'h00, 8'h77);
        sendPkt(4'hF, 2'b10, 8'h33, 8'h00);
        sendPkt(4'h1, 2'b00, 8'h00, 8'hA1);
        sendPkt(4'h2, 2'b00, 8'h00, 8'hA2);
        sendPkt(4'h3, 2'b00, 8'h00, 8'hA3);
        sendPkt(4'h9, 2'b00, 8'h00, 8'hA4);
        waitIssue("errs");
        chk("lit_err_psum", 64'(bus.add_psum), 64'hA4_A3A2_A111);
        chk("lit_err_mem", 64'(bus.add_mem_pot), 64'h0);
        chk("lit_err_use_mem", 64'(bus.add_use_mem), 64'h0);
        chk("lit_err_ts", 64'(bus.add_ts), 64'h0);
        chk("lit_err_count", 64'(errCount - errBase), 64'h3);
        doHandshake();

        // ts=1 round reaches ISSUE; reset wins over a simultaneous handshake.
        sendPkt(4'h0, 2'b00, 8'h00, 8'h41);
        sendPkt(4'h1, 2'b00, 8'h00, 8'h42);
        sendPkt(4'h2, 2'b00, 8'h00, 8'h43);
        sendPkt(4'h3, 2'b00, 8'h00, 8'h44);
        sendPkt(4'h9, 2'b00, 8'h00, 8'h45);
        sendPkt(4'hF, 2'b10, 8'h5A, 8'h00);
        chk("lit_pre_rst_valid", 64'(bus.add_valid), 64'h1);
        reset = 1'b1;
        bus.add_ready = 1'b1;
        @(posedge clk); #1;
        chk("lit_rst2_valid", 64'(bus.add_valid), 64'h0);
        chk("lit_rst2_psum", 64'(bus.add_psum), 64'h0);
        chk("lit_rst2_ts", 64'(bus.add_ts), 64'h0);
        chk("lit_rst2_done", 64'(bus.round_done), 64'h0);
        bus.add_ready = 1'b0;
        reset = 1'b0;

        // Three slots pending, then reset again: all five are needed afterwards.
        sendPkt(4'h0, 2'b00, 8'h00, 8'h61);
        sendPkt(4'h1, 2'b00, 8'h00, 8'h62);
        sendPkt(4'h2, 2'b00, 8'h00, 8'h63);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sendPkt(4'h3, 2'b00, 8'h00, 8'h74);
        sendPkt(4'h9, 2'b00, 8'h00, 8'h75);
        sendPkt(4'h0, 2'b00, 8'h00, 8'h71);
        sendPkt(4'h1, 2'b00, 8'h00, 8'h72);
        chk("lit_rst3_partial", 64'(bus.add_valid), 64'h0);
        sendPkt(4'h2, 2'b00, 8'h00, 8'h73);
        chk("lit_rst3_valid", 64'(bus.add_valid), 64'h1);
        chk("lit_rst3_psum", 64'(bus.add_psum), 64'h75_7473_7271);
        chk("lit_rst3_ts", 64'(bus.add_ts), 64'h0);
        chk("lit_rst3_use_mem", 64'(bus.add_use_mem), 64'h0);
        doHandshake();
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
